// File: rtl/parking_pkg.sv
// Shared types and default sizing for the car park occupancy controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package parking_pkg;

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_OPEN  = 2'd1,
    G_CLOSE = 2'd2
  } gate_state_t;

  localparam int DEF_CAP_W    = 8;
  localparam int DEF_CAPACITY = 200;
  localparam int DEF_TIMEOUT  = 1000;
  localparam int DEF_TO_W     = 10;

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier: IDLE -> OPEN on req&grant, OPEN -> CLOSE on pass or timeout, CLOSE -> IDLE.
// Latency: gate_open/refused are registered, 1 cycle after req; accepted is same-cycle with the pass.
// Backpressure: no grant keeps the FSM in IDLE and pulses refused at most every other cycle.
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TO_W      = DEF_TO_W,
  parameter bit STRAY_ERR = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic grant_i,
  input  logic passed_i,
  output logic gate_open_o,
  output logic accepted_o,
  output logic refused_o,
  output logic in_open_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  gate_state_t     state_q, state_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic            gate_open_q;
  logic            refused_q, refused_d;

  // Next state, timer and refusal pulse; accepted marks a pass that counts this edge.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    refused_d  = 1'b0;
    accepted_o = 1'b0;
    case (state_q)
      G_IDLE: begin
        if (req_i) begin
          if (grant_i) begin
            state_d = G_OPEN;
            timer_d = '0;
          end else if (!refused_q) begin
            // Suppressing back-to-back pulses limits a held request to one pulse per 2 cycles.
            refused_d = 1'b1;
          end
        end
      end
      G_OPEN: begin
        timer_d = timer_q + TO_ONE;
        if (passed_i) begin
          state_d    = G_CLOSE;
          accepted_o = 1'b1;
        end else if (timer_q == TO_LAST) begin
          state_d = G_CLOSE;
        end
      end
      G_CLOSE: begin
        state_d = G_IDLE;
      end
      default: begin
        state_d = G_IDLE;
      end
    endcase
    // A pass seen outside OPEN while the grant condition is false is an error on gates that report it.
    if (STRAY_ERR && passed_i && (state_q != G_OPEN) && !grant_i) begin
      refused_d = 1'b1;
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= G_IDLE;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
      refused_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gate_open_q <= (state_d == G_OPEN);
      refused_q   <= refused_d;
    end
  end

  assign gate_open_o = gate_open_q;
  assign refused_o   = refused_q;
  // Next-cycle OPEN, so the parent can register a reservation aligned with gate_open.
  assign in_open_o   = (state_d == G_OPEN);

endmodule

// File: rtl/parking_gate_controller.sv
// Car park occupancy: entry/exit gate FSMs, registered occupancy, entry reservation and flags.
// Latency: all outputs registered, 1 cycle after the request/pass that changes them.
// Backpressure: entry refused (entry_denied) when no free space; exit refused (exit_error) when empty.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int CAP_W    = DEF_CAP_W,
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int TO_W     = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_req,
  input  logic             entry_passed,
  input  logic             exit_req,
  input  logic             exit_passed,
  output logic             entry_gate_open,
  output logic             exit_gate_open,
  output logic             entry_denied,
  output logic             exit_error,
  output logic [CAP_W-1:0] occupied,
  output logic [CAP_W-1:0] free_spaces,
  output logic             full,
  output logic             empty
);

  localparam logic [CAP_W-1:0] CAP_N = CAP_W'(CAPACITY);
  localparam logic [CAP_W-1:0] ONE   = CAP_W'(1);
  localparam logic [CAP_W:0]   CAP_X = (CAP_W + 1)'(CAPACITY);

  logic [CAP_W-1:0] occ_q, occ_d;
  logic [CAP_W-1:0] free_q, free_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [CAP_W:0]   used_x;

  logic entry_grant, exit_grant;
  logic entry_acc, exit_acc;
  logic entry_resv_d;
  logic exit_open_next_unused;

  // Grants only look at registered counts: no same-cycle bypass from a pass.
  assign entry_grant = (free_q != '0);
  assign exit_grant  = (occ_q != '0);

  parking_gate_fsm #(
    .TIMEOUT  (TIMEOUT),
    .TO_W     (TO_W),
    .STRAY_ERR(1'b0)
  ) u_entry (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (entry_req),
    .grant_i    (entry_grant),
    .passed_i   (entry_passed),
    .gate_open_o(entry_gate_open),
    .accepted_o (entry_acc),
    .refused_o  (entry_denied),
    .in_open_o  (entry_resv_d)
  );

  parking_gate_fsm #(
    .TIMEOUT  (TIMEOUT),
    .TO_W     (TO_W),
    .STRAY_ERR(1'b1)
  ) u_exit (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (exit_req),
    .grant_i    (exit_grant),
    .passed_i   (exit_passed),
    .gate_open_o(exit_gate_open),
    .accepted_o (exit_acc),
    .refused_o  (exit_error),
    .in_open_o  (exit_open_next_unused)
  );

  // Next occupancy (clamped to 0..CAPACITY) and free/full/empty derived from it and the reservation.
  always_comb begin
    occ_d = occ_q;
    if (entry_acc && !exit_acc && (occ_q < CAP_N)) begin
      occ_d = occ_q + ONE;
    end else if (exit_acc && !entry_acc && (occ_q != '0)) begin
      occ_d = occ_q - ONE;
    end
    used_x  = {1'b0, occ_d} + (CAP_W + 1)'(entry_resv_d);
    free_d  = (used_x >= CAP_X) ? '0 : CAP_W'(CAP_X - used_x);
    full_d  = (free_d == '0);
    empty_d = (occ_d == '0);
  end

  // Counts and flags update together so they agree in every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= '0;
      free_q  <= CAP_N;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      occ_q   <= occ_d;
      free_q  <= free_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign occupied    = occ_q;
  assign free_spaces = free_q;
  assign full        = full_q;
  assign empty       = empty_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: a 200-space instance and a 3-space instance.
// Latency: each vector is driven for one cycle and checked 1 time unit after the next rising edge.
// Backpressure: n/a.
module tb_parking_gate_controller;

  localparam int CAP_A = 200;
  localparam int CAP_B = 3;
  localparam int TO    = 1000;

  typedef struct {
    int d;
    bit er, ep, xr, xp;
    bit eo, xo, den, xe;
    int occ, fre;
    bit ful, emp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       er [2], ep [2], xr [2], xp [2];
  logic       eo [2], xo [2], den [2], xe [2], ful [2], emp [2];
  logic [7:0] occ [2], fre [2];

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  parking_gate_controller #(.CAP_W(8), .CAPACITY(CAP_A), .TIMEOUT(TO), .TO_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n[0]),
    .entry_req(er[0]), .entry_passed(ep[0]), .exit_req(xr[0]), .exit_passed(xp[0]),
    .entry_gate_open(eo[0]), .exit_gate_open(xo[0]), .entry_denied(den[0]), .exit_error(xe[0]),
    .occupied(occ[0]), .free_spaces(fre[0]), .full(ful[0]), .empty(emp[0])
  );

  parking_gate_controller #(.CAP_W(8), .CAPACITY(CAP_B), .TIMEOUT(TO), .TO_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n[1]),
    .entry_req(er[1]), .entry_passed(ep[1]), .exit_req(xr[1]), .exit_passed(xp[1]),
    .entry_gate_open(eo[1]), .exit_gate_open(xo[1]), .entry_denied(den[1]), .exit_error(xe[1]),
    .occupied(occ[1]), .free_spaces(fre[1]), .full(ful[1]), .empty(emp[1])
  );

  function automatic vec_t mk(int d, int er_, int ep_, int xr_, int xp_,
                              int eo_, int xo_, int den_, int xe_, int occ_, int fre_);
    vec_t v;
    v.d   = d;
    v.er  = (er_ != 0);
    v.ep  = (ep_ != 0);
    v.xr  = (xr_ != 0);
    v.xp  = (xp_ != 0);
    v.eo  = (eo_ != 0);
    v.xo  = (xo_ != 0);
    v.den = (den_ != 0);
    v.xe  = (xe_ != 0);
    v.occ = occ_;
    v.fre = fre_;
    v.ful = (fre_ == 0);
    v.emp = (occ_ == 0);
    return v;
  endfunction

  // One car in: request (gate opens, space reserved), pass, then a quiet cycle for CLOSE -> IDLE.
  function automatic void add_entry(int d, int n, int cap);
    tbl.push_back(mk(d, 1, 0, 0, 0, 1, 0, 0, 0, n,     cap - n - 1));
    tbl.push_back(mk(d, 1, 1, 0, 0, 0, 0, 0, 0, n + 1, cap - n - 1));
    tbl.push_back(mk(d, 0, 0, 0, 0, 0, 0, 0, 0, n + 1, cap - n - 1));
  endfunction

  task automatic chk(string nm, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic check_out(vec_t v, string tag);
    chk({tag, " entry_gate_open"}, int'(eo[v.d]),  int'(v.eo));
    chk({tag, " exit_gate_open"},  int'(xo[v.d]),  int'(v.xo));
    chk({tag, " entry_denied"},    int'(den[v.d]), int'(v.den));
    chk({tag, " exit_error"},      int'(xe[v.d]),  int'(v.xe));
    chk({tag, " occupied"},        int'(occ[v.d]), v.occ);
    chk({tag, " free_spaces"},     int'(fre[v.d]), v.fre);
    chk({tag, " full"},            int'(ful[v.d]), int'(v.ful));
    chk({tag, " empty"},           int'(emp[v.d]), int'(v.emp));
  endtask

  task automatic drive(int d, bit a, bit b, bit c, bit e);
    er[d] = a;
    ep[d] = b;
    xr[d] = c;
    xp[d] = e;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare once the DUT has clocked it.
  task automatic step(vec_t v, string tag);
    vec_t exp_v;
    drive(v.d, v.er, v.ep, v.xr, v.xp);
    sb.push_back(v);
    @(posedge clk);
    #1;
    drive(v.d, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    check_out(exp_v, tag);
  endtask

  task automatic run_tbl(string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("%s[%0d]", tag, i));
    end
    tbl.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int open_cycles;
    int mid_free;

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      drive(d, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    check_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CAP_A), "reset_a");
    check_out(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CAP_B), "reset_b");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Instance A: exit at empty, stray passes in IDLE.
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 200));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 200));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 200));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 200));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 200));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 200));
    // Instance A: first car, pass 3 cycles after the gate opens.
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 199));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 199));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 199));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 199));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 199));
    for (int n = 1; n < 5; n++) add_entry(0, n, CAP_A);
    // Instance A at 5 cars: both gates open, both pass in the same cycle.
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 5, 194));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 5, 195));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 195));
    // Instance B: fill all 3 spaces, then deny, exit, no bypass, re-grant.
    for (int n = 0; n < 3; n++) add_entry(1, n, CAP_B);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 2, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    run_tbl("tbl");

    // Entry timeout on A: open for exactly TO cycles, reservation returned, count kept.
    step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 194), "to_open");
    open_cycles = 1;
    mid_free    = -1;
    for (int i = 0; i < TO + 100; i++) begin
      @(posedge clk);
      #1;
      if (i == TO / 2) mid_free = int'(fre[0]);
      if (!eo[0]) break;
      open_cycles++;
    end
    chk("timeout_open_cycles", open_cycles, TO);
    chk("timeout_mid_free", mid_free, 194);
    check_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 195), "after_timeout");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 195), "to_idle");

    // Async reset on A with both gates open and 7 cars inside.
    add_entry(0, 5, CAP_A);
    add_entry(0, 6, CAP_A);
    run_tbl("fill7");
    step(mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 7, 192), "both_open");
    #2;
    rst_n[0] = 1'b0;
    #1;
    check_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CAP_A), "async_reset");
    #2;
    rst_n[0] = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CAP_A), "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
